// File: rtl/tc_sram_banked.sv
// Multi-port, word-interleaved banked SRAM with per-bank round-robin arbitration
// and a fixed-latency read return pipeline per port.
module tc_sram_banked #(
  parameter int unsigned NumWords  = 32'd256,
  parameter int unsigned DataWidth = 32'd32,
  parameter int unsigned ByteWidth = 32'd8,
  parameter int unsigned NumPorts  = 32'd4,
  parameter int unsigned NumBanks  = 32'd4,
  parameter int unsigned Latency   = 32'd1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  output logic [NumPorts-1:0]                 gnt_o,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  localparam int unsigned BankSel   = $clog2(NumBanks);
  localparam int unsigned BankW     = (BankSel > 0) ? BankSel : 1;
  localparam int unsigned BankWords = NumWords / NumBanks;
  localparam int unsigned RowWidth  = (BankWords > 1) ? $clog2(BankWords) : 1;
  localparam int unsigned PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  // Handshake: a request is accepted in the cycle gnt_o is high; an ungranted
  // requester holds req_i and its payload until that cycle. No backpressure on rvalid_o.

  logic [NumPorts-1:0][BankW-1:0]     port_bank;
  logic [NumPorts-1:0][RowWidth-1:0]  port_row;
  logic [NumPorts-1:0]                port_inr;
  logic [NumPorts-1:0][DataWidth-1:0] port_mask;
  logic [NumPorts-1:0][DataWidth-1:0] rd_word;

  logic [NumBanks-1:0]                bank_gnt;
  logic [NumBanks-1:0][PortW-1:0]     win_idx;
  logic [NumBanks-1:0][PortW-1:0]     ptr_q, ptr_d;

  logic [DataWidth-1:0] mem_q [NumBanks][BankWords];

  logic [NumPorts-1:0][Latency-1:0]                vld_q, vld_d;
  logic [NumPorts-1:0][Latency-1:0][DataWidth-1:0] dat_q, dat_d;

  always_comb begin
    port_bank = '0;
    port_row  = '0;
    port_inr  = '0;
    port_mask = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (NumBanks > 1) port_bank[p] = addr_i[p][BankW-1:0];
      port_row[p] = RowWidth'(addr_i[p] >> BankSel);
      port_inr[p] = (32'(addr_i[p]) < NumWords);
      for (int k = 0; k < DataWidth; k++) port_mask[p][k] = be_i[p][k/ByteWidth];
    end
  end

  // Per bank: scan ports starting at the pointer, first requester wins.
  always_comb begin
    bank_gnt = '0;
    win_idx  = '0;
    gnt_o    = '0;
    ptr_d    = ptr_q;
    for (int b = 0; b < NumBanks; b++) begin
      for (int i = 0; i < NumPorts; i++) begin
        int idx;
        idx = int'(ptr_q[b]) + i;
        if (idx >= int'(NumPorts)) idx = idx - int'(NumPorts);
        if (!bank_gnt[b] && req_i[idx] && (port_bank[idx] == BankW'(b))) begin
          bank_gnt[b] = 1'b1;
          win_idx[b]  = PortW'(idx);
        end
      end
      if (bank_gnt[b]) begin
        gnt_o[win_idx[b]] = 1'b1;
        if (int'(win_idx[b]) == int'(NumPorts) - 1) ptr_d[b] = '0;
        else                                         ptr_d[b] = win_idx[b] + PortW'(1);
      end
    end
    if (!rst_ni) begin
      gnt_o    = '0;
      bank_gnt = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  // Out-of-range accesses are granted but never touch the array.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBanks; b++) begin
      if (bank_gnt[b] && we_i[win_idx[b]] && port_inr[win_idx[b]]) begin
        mem_q[b][port_row[win_idx[b]]] <=
          (mem_q[b][port_row[win_idx[b]]] & ~port_mask[win_idx[b]]) |
          (wdata_i[win_idx[b]] & port_mask[win_idx[b]]);
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (port_inr[p]) rd_word[p] = mem_q[port_bank[p]][port_row[p]];
    end
  end

  // Data stages load only alongside a valid, so the last stage holds the last response.
  always_comb begin
    vld_d = '0;
    dat_d = dat_q;
    for (int p = 0; p < NumPorts; p++) begin
      vld_d[p][0] = gnt_o[p] & ~we_i[p];
      if (vld_d[p][0]) dat_d[p][0] = rd_word[p];
      for (int k = 1; k < Latency; k++) begin
        vld_d[p][k] = vld_q[p][k-1];
        if (vld_q[p][k-1]) dat_d[p][k] = dat_q[p][k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      rvalid_o[p] = vld_q[p][Latency-1];
      rdata_o[p]  = dat_q[p][Latency-1];
    end
  end

endmodule
